// File: rtl/ap_bus_arbiter.sv
// Two-requester round-robin bus arbiter with bounded burst lock and stall timeout abort.
// Requester 0 is the JTAG AHB access point; requester 1 is a second debug bus master.
module ap_bus_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              AFT_CLK,
  input  logic              nRST,
  input  logic              req0_ren,
  input  logic              req0_wen,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [3:0]        req0_strobe,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_stall,
  output logic              req0_err,
  input  logic              req1_ren,
  input  logic              req1_wen,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [3:0]        req1_strobe,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_stall,
  output logic              req1_err,
  output logic              bus_ren,
  output logic              bus_wen,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_strobe,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_request_stall,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StXfer, StAbort} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [TW-1:0] timer_q, timer_d;

  logic              act0, act1, own_act, oth_act;
  logic              own_ren, own_wen, completion;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic [3:0]        own_strobe;

  assign act0       = req0_ren | req0_wen;
  assign act1       = req1_ren | req1_wen;
  assign own_act    = owner_q ? act1 : act0;
  assign oth_act    = owner_q ? act0 : act1;
  assign own_ren    = owner_q ? req1_ren : req0_ren;
  assign own_wen    = owner_q ? req1_wen : req0_wen;
  assign own_addr   = owner_q ? req1_addr : req0_addr;
  assign own_wdata  = owner_q ? req1_wdata : req0_wdata;
  assign own_strobe = owner_q ? req1_strobe : req0_strobe;
  assign completion = (state_q == StXfer) && own_act && !bus_request_stall;

  always_ff @(posedge AFT_CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      burst_cnt_q  <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    timer_d      = timer_q;
    unique case (state_q)
      StIdle: begin
        if (act0 || act1) begin
          owner_d     = (act0 && act1) ? ~last_grant_q : act1;
          state_d     = StXfer;
          burst_cnt_d = '0;
          timer_d     = '0;
        end
      end
      StXfer: begin
        if (!own_act) begin
          state_d      = StIdle;
          last_grant_d = owner_q;
        end else if (!bus_request_stall) begin
          timer_d = '0;
          // Hand the bus over when the other side waits or the burst quota is used up.
          if (oth_act || (burst_cnt_q == BW'(MAX_BURST - 1))) begin
            state_d      = StIdle;
            last_grant_d = owner_q;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = StAbort;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StAbort: begin
        state_d      = StIdle;
        last_grant_d = owner_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_ren    = 1'b0;
    bus_wen    = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_strobe = '0;
    req0_rdata = '0;
    req1_rdata = '0;
    req0_stall = act0;
    req1_stall = act1;
    req0_err   = 1'b0;
    req1_err   = 1'b0;
    if (state_q == StXfer) begin
      // Simultaneous ren and wen is treated as a write.
      bus_ren    = own_ren & ~own_wen;
      bus_wen    = own_wen;
      bus_addr   = own_addr;
      bus_wdata  = own_wdata;
      bus_strobe = own_strobe;
      if (owner_q) begin
        req1_stall = ~completion;
        req1_rdata = bus_rdata;
      end else begin
        req0_stall = ~completion;
        req0_rdata = bus_rdata;
      end
    end else if (state_q == StAbort) begin
      if (owner_q) begin
        req1_stall = 1'b0;
        req1_err   = 1'b1;
      end else begin
        req0_stall = 1'b0;
        req0_err   = 1'b1;
      end
    end
  end

  assign grant = (state_q == StIdle) ? 2'b00 : {owner_q, ~owner_q};
  assign busy  = (state_q != StIdle);

endmodule
